// File: rtl/register_file_mp_if.sv
// Command and read-port bundle between the control unit (master) and the register file (slave).
interface register_file_mp_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op_code;
    logic [ADDR_W-1:0] addr_w;
    logic [WIDTH-1:0]  data_w;
    logic [ADDR_W-1:0] addr_r1;
    logic [ADDR_W-1:0] addr_r2;
    logic [WIDTH-1:0]  read1;
    logic [WIDTH-1:0]  read2;
    logic              busy;
    logic              clear_done;

    modport master (
        output op_valid, op_code, addr_w, data_w, addr_r1, addr_r2,
        input  op_ready, read1, read2, busy, clear_done
    );

    modport slave (
        input  op_valid, op_code, addr_w, data_w, addr_r1, addr_r2,
        output op_ready, read1, read2, busy, clear_done
    );
endinterface

// File: rtl/register_file_mp.sv
// Multi-mode register file: 2 comb read ports, WRITE/SWAP in one edge, CLEAR sweeps DEPTH cycles.
// Reads are combinational (optional write bypass); op_ready is low for the whole sweep, commands then are dropped.
module register_file_mp #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic clock,
    input  logic reset,
    register_file_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {OP_NOP, OP_WRITE, OP_SWAP, OP_CLEAR} op_t;
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              clear_done_q, clear_done_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];

    op_t  op;
    logic accept;
    logic wr_discard;
    logic wr_fwd;

    assign op         = op_t'(bus.op_code);
    assign accept     = bus.op_valid && bus.op_ready;
    assign wr_discard = (ZERO_R0 != 0) && (bus.addr_w == '0);
    assign wr_fwd     = (BYPASS != 0) && accept && (op == OP_WRITE) && !wr_discard;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        clear_done_d = 1'b0;
        regs_d       = regs_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_WRITE: begin
                            if (!wr_discard) regs_d[bus.addr_w] = bus.data_w;
                        end
                        OP_SWAP: begin
                            if (bus.addr_r1 != bus.addr_r2) begin
                                regs_d[bus.addr_r1] = regs_q[bus.addr_r2];
                                regs_d[bus.addr_r2] = regs_q[bus.addr_r1];
                            end
                        end
                        OP_CLEAR: begin
                            state_d = SWEEP;
                            ptr_d   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            SWEEP: begin
                regs_d[ptr_q] = '0;
                ptr_d         = ptr_q + 1'b1;
                if (ptr_q == LAST_ADDR) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Swapping with r0 must leave r0 pinned at zero while the partner takes r0's zero.
        if (ZERO_R0 != 0) regs_d[0] = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            clear_done_q <= 1'b0;
            regs_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            clear_done_q <= clear_done_d;
            regs_q       <= regs_d;
        end
    end

    assign bus.busy       = (state_q == SWEEP);
    assign bus.op_ready   = !bus.busy;
    assign bus.clear_done = clear_done_q;

    assign bus.read1 = (wr_fwd && bus.addr_w == bus.addr_r1) ? bus.data_w :
                       ((ZERO_R0 != 0) && bus.addr_r1 == '0) ? '0 : regs_q[bus.addr_r1];
    assign bus.read2 = (wr_fwd && bus.addr_w == bus.addr_r2) ? bus.data_w :
                       ((ZERO_R0 != 0) && bus.addr_r2 == '0) ? '0 : regs_q[bus.addr_r2];
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp; a second instance with BYPASS=0 mirrors every command.
module tb_register_file_mp;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    register_file_mp_if #(.WIDTH(32), .ADDR_W(5)) bus ();
    register_file_mp_if #(.WIDTH(32), .ADDR_W(5)) bus_nb ();

    register_file_mp #(.WIDTH(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    register_file_mp #(.WIDTH(32), .ADDR_W(5), .ZERO_R0(1), .BYPASS(0)) dut_nb (
        .clock (clock),
        .reset (reset),
        .bus   (bus_nb.slave)
    );

    assign bus_nb.op_valid = bus.op_valid;
    assign bus_nb.op_code  = bus.op_code;
    assign bus_nb.addr_w   = bus.addr_w;
    assign bus_nb.data_w   = bus.data_w;
    assign bus_nb.addr_r1  = bus.addr_r1;
    assign bus_nb.addr_r2  = bus.addr_r2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] code, input logic [4:0] aw, input logic [31:0] dw,
                         input logic [4:0] a1, input logic [4:0] a2);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.addr_w   = aw;
        bus.data_w   = dw;
        bus.addr_r1  = a1;
        bus.addr_r2  = a2;
    endtask

    task automatic do_op(input logic [1:0] code, input logic [4:0] aw, input logic [31:0] dw,
                         input logic [4:0] a1, input logic [4:0] a2);
        drive(code, aw, dw, a1, a2);
        tick();
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        bus.addr_r1 = a1;
        bus.addr_r2 = a2;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_code  = 2'b00;
        bus.addr_w   = '0;
        bus.data_w   = '0;
        bus.addr_r1  = '0;
        bus.addr_r2  = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_clear_done", 32'(bus.clear_done), 32'd0);
        rd(5'd5, 5'd31);
        check("rst_r5", bus.read1, 32'h0);
        check("rst_r31", bus.read2, 32'h0);

        do_op(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        rd(5'd5, 5'd0);
        check("wr_r5", bus.read1, 32'hDEADBEEF);
        do_op(2'b01, 5'd0, 32'h1234, 5'd0, 5'd0);
        rd(5'd0, 5'd0);
        check("wr_r0_discard", bus.read1, 32'h0);

        // Same-cycle write to r7 observed through read2 before the edge.
        drive(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd7);
        #1;
        check("bypass_on_r7", bus.read2, 32'hA5A5A5A5);
        check("bypass_off_r7_pre", bus_nb.read2, 32'h0);
        tick();
        bus.op_valid = 1'b0;
        check("bypass_off_r7_post", bus_nb.read2, 32'hA5A5A5A5);
        drive(2'b01, 5'd0, 32'hCAFE0000, 5'd0, 5'd7);
        #1;
        check("bypass_r0_blocked", bus.read1, 32'h0);
        tick();
        bus.op_valid = 1'b0;

        do_op(2'b01, 5'd3, 32'h11, 5'd0, 5'd0);
        do_op(2'b01, 5'd9, 32'h22, 5'd0, 5'd0);
        drive(2'b10, 5'd0, 32'h0, 5'd3, 5'd9);
        #1;
        check("swap_no_bypass", bus.read1, 32'h11);
        tick();
        bus.op_valid = 1'b0;
        rd(5'd3, 5'd9);
        check("swap_r3", bus.read1, 32'h22);
        check("swap_r9", bus.read2, 32'h11);
        do_op(2'b01, 5'd4, 32'h44, 5'd0, 5'd0);
        do_op(2'b10, 5'd0, 32'h0, 5'd4, 5'd4);
        rd(5'd4, 5'd4);
        check("swap_same", bus.read1, 32'h44);
        do_op(2'b01, 5'd6, 32'h77, 5'd0, 5'd0);
        do_op(2'b10, 5'd0, 32'h0, 5'd0, 5'd6);
        rd(5'd0, 5'd6);
        check("swap_r0_r0", bus.read1, 32'h0);
        check("swap_r0_r6", bus.read2, 32'h0);

        for (int i = 1; i < 32; i++) do_op(2'b01, 5'(i), 32'(i), 5'd0, 5'd0);
        do_op(2'b11, 5'd0, 32'h0, 5'd0, 5'd0);
        check("sweep_ready_low", 32'(bus.op_ready), 32'd0);
        cnt = 0;
        while (bus.busy && cnt < 100) begin
            cnt++;
            if (cnt == 5) begin
                drive(2'b01, 5'd2, 32'hFF, 5'd20, 5'd1);
                #1;
                check("sweep_mid_r20", bus.read1, 32'd20);
                check("sweep_mid_r1", bus.read2, 32'h0);
            end else begin
                bus.op_valid = 1'b0;
            end
            tick();
        end
        bus.op_valid = 1'b0;
        check("sweep_busy_cycles", 32'(cnt), 32'd32);
        check("sweep_done_pulse", 32'(bus.clear_done), 32'd1);
        check("sweep_done_ready", 32'(bus.op_ready), 32'd1);
        do_op(2'b01, 5'd2, 32'hFF, 5'd0, 5'd0);
        check("sweep_done_low", 32'(bus.clear_done), 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'd0);
            check($sformatf("post_sweep_r%0d", i), bus.read1, (i == 2) ? 32'hFF : 32'h0);
        end

        do_op(2'b01, 5'd20, 32'h55, 5'd0, 5'd0);
        do_op(2'b01, 5'd5, 32'h5, 5'd0, 5'd0);
        do_op(2'b11, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int i = 0; i < 10; i++) tick();
        rd(5'd20, 5'd5);
        check("abort_mid_r20", bus.read1, 32'h55);
        check("abort_mid_r5", bus.read2, 32'h0);
        check("abort_mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_no_done", 32'(bus.clear_done), 32'd0);
        rd(5'd20, 5'd0);
        check("abort_r20", bus.read1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_no_done_late", 32'(bus.clear_done), 32'd0);
        end

        do_op(2'b01, 5'd8, 32'h33, 5'd0, 5'd0);
        reset = 1'b1;
        do_op(2'b01, 5'd8, 32'h99, 5'd0, 5'd0);
        reset = 1'b0;
        rd(5'd8, 5'd8);
        check("reset_wins_r8", bus.read1, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
